// File: rtl/unified_buffer_param.sv
// Parametrised activation/result buffer: lane-wide stores, host preload, and a
// burst-load FSM that streams LANES-word groups to the input-setup stage with backpressure.
module unified_buffer_param #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int LANES  = 4,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    host_wr_en,
    input  logic [ADDR_W-1:0]       host_wr_addr,
    input  logic [DATA_W-1:0]       host_wr_data,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [LANES*DATA_W-1:0] st_data,
    input  logic                    ld_start,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [CNT_W-1:0]        ld_count,
    output logic                    ld_busy,
    output logic                    ld_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t                  state_q;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
    logic [LANES*DATA_W-1:0] out_data_q;
    logic [LANES*DATA_W-1:0] group_rd;
    logic [ADDR_W-1:0]       st_lane_addr [LANES];
    logic                    out_valid_q, ld_done_q;
    logic                    issue, st_fire;

    assign st_ready  = (state_q == IDLE);
    assign ld_busy   = (state_q != IDLE);
    assign ld_done   = ld_done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    assign st_fire = st_valid && st_ready;
    assign issue   = !out_valid_q || out_ready;
    assign ptr_d   = ptr_q + ADDR_W'(LANES);
    assign rem_d   = rem_q - 1'b1;

    // Lane addresses wrap modulo DEPTH through natural ADDR_W overflow.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign group_rd[gi*DATA_W +: DATA_W] = mem_q[ptr_q + ADDR_W'(gi)];
            assign st_lane_addr[gi]              = st_addr + ADDR_W'(gi);
        end
    endgenerate

    // Store lanes are assigned after the host write so they win on a same-word collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else begin
            if (host_wr_en) begin
                mem_q[host_wr_addr] <= host_wr_data;
            end
            if (st_fire) begin
                for (int i = 0; i < LANES; i++) begin
                    mem_q[st_lane_addr[i]] <= st_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ld_done_q   <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_start) begin
                        if (ld_count != '0) begin
                            state_q <= LOAD;
                            ptr_q   <= ld_addr;
                            rem_q   <= ld_count;
                        end else begin
                            ld_done_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // group_rd samples the memory before this edge's writes land.
                    if (issue) begin
                        out_data_q  <= group_rd;
                        out_valid_q <= 1'b1;
                        ptr_q       <= ptr_d;
                        rem_q       <= rem_d;
                        if (rem_d == '0) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        ld_done_q   <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_buffer_param.sv
// Scoreboard bench for unified_buffer_param: expected groups are queued as stimulus is
// driven and matched against groups captured at each out_valid/out_ready handshake.
module tb_unified_buffer_param;

    localparam int DW = 32;
    localparam int DEPTH = 64;
    localparam int L = 4;
    localparam int AW = 6;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              host_wr_en = 1'b0;
    logic [AW-1:0]     host_wr_addr = '0;
    logic [DW-1:0]     host_wr_data = '0;
    logic              st_valid = 1'b0;
    logic              st_ready;
    logic [AW-1:0]     st_addr = '0;
    logic [L*DW-1:0]   st_data = '0;
    logic              ld_start = 1'b0;
    logic [AW-1:0]     ld_addr = '0;
    logic [CW-1:0]     ld_count = '0;
    logic              ld_busy;
    logic              ld_done;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [L*DW-1:0]   out_data;

    unified_buffer_param #(.DATA_W(DW), .DEPTH(DEPTH), .LANES(L), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_start(ld_start), .ld_addr(ld_addr), .ld_count(ld_count),
        .ld_busy(ld_busy), .ld_done(ld_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [L*DW-1:0] exp_q[$];
    logic [L*DW-1:0] got_q[$];
    int hs, done_cnt, unstable, st_bad, timeout, first_valid;
    logic busy_after;
    logic have_hold;
    logic [L*DW-1:0] hold;

    function automatic logic [L*DW-1:0] pack4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic drive_cycle(input logic hen, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                               input logic sv, input logic [AW-1:0] sa, input logic [L*DW-1:0] sd);
        @(negedge clk);
        host_wr_en = hen; host_wr_addr = ha; host_wr_data = hd;
        st_valid = sv; st_addr = sa; st_data = sd;
        @(negedge clk);
        host_wr_en = 1'b0; st_valid = 1'b0;
    endtask

    // Runs one burst and records handshakes; optional host write lands on the first issue edge.
    task automatic run_burst(input logic [AW-1:0] addr, input logic [CW-1:0] cnt, input int stall,
                             input logic hen, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        got_q.delete();
        hs = 0; done_cnt = 0; unstable = 0; st_bad = 0; timeout = 1; first_valid = -1;
        have_hold = 1'b0;
        @(negedge clk);
        ld_start = 1'b1; ld_addr = addr; ld_count = cnt; out_ready = (stall == 0);
        @(negedge clk);
        ld_start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc == 0) begin
                host_wr_en = hen; host_wr_addr = ha; host_wr_data = hd;
            end else begin
                host_wr_en = 1'b0;
            end
            if (ld_done) begin
                done_cnt++; timeout = 0;
                break;
            end
            if (ld_busy && st_ready) st_bad++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid) begin
                if (stall > 0) begin
                    out_ready = 1'b0; stall--;
                end else begin
                    out_ready = 1'b1;
                end
            end
            if (out_valid && !out_ready) begin
                if (have_hold && out_data !== hold) unstable++;
                hold = out_data; have_hold = 1'b1;
            end else begin
                have_hold = 1'b0;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data); hs++;
            end
            @(negedge clk);
        end
        host_wr_en = 1'b0;
        @(negedge clk);
        if (ld_done) done_cnt++;
        busy_after = ld_busy;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        vec_cnt++;
        if ({out_valid, ld_done, ld_busy, st_ready} !== 4'b0001) begin
            err_cnt++;
            $display("FAIL reset_flags: got v/d/b/r=%b required 0001", {out_valid, ld_done, ld_busy, st_ready});
        end
        vec_cnt++;
        if (out_data !== '0) begin
            err_cnt++;
            $display("FAIL reset_data: got %h required 0", out_data);
        end
        $display("reset: out_valid=%b st_ready=%b out_data=%h", out_valid, st_ready, out_data);
    endtask

    task automatic test_preload;
        drive_cycle(1'b1, 6'd30, 32'd11, 1'b0, '0, '0);
        drive_cycle(1'b1, 6'd31, 32'd12, 1'b0, '0, '0);
        drive_cycle(1'b1, 6'd32, 32'd21, 1'b0, '0, '0);
        drive_cycle(1'b1, 6'd33, 32'd22, 1'b0, '0, '0);
        exp_q.push_back(pack4(32'd11, 32'd12, 32'd21, 32'd22));
        run_burst(6'd30, 8'd1, 0, 1'b0, '0, '0);
        vec_cnt++;
        if (hs !== 1 || done_cnt !== 1 || timeout !== 0 || busy_after !== 1'b0) begin
            err_cnt++;
            $display("FAIL preload_ctrl: got hs=%0d done=%0d timeout=%0d busy=%b required 1 1 0 0", hs, done_cnt, timeout, busy_after);
        end
        vec_cnt++;
        if (first_valid !== 1) begin
            err_cnt++;
            $display("FAIL preload_latency: got first valid at cycle %0d required 1", first_valid);
        end
        while (exp_q.size() > 0) begin
            logic [L*DW-1:0] e;
            e = exp_q.pop_front();
            vec_cnt++;
            if (got_q.size() == 0) begin
                err_cnt++; $display("FAIL preload_data: got nothing required %h", e);
            end else begin
                logic [L*DW-1:0] g;
                g = got_q.pop_front();
                if (g !== e) begin err_cnt++; $display("FAIL preload_data: got %h required %h", g, e); end
                $display("preload: group %h", g);
            end
        end
    endtask

    task automatic test_store_burst;
        drive_cycle(1'b0, '0, '0, 1'b1, 6'd0, pack4(1, 2, 3, 4));
        drive_cycle(1'b0, '0, '0, 1'b1, 6'd4, pack4(5, 6, 7, 8));
        exp_q.push_back(pack4(1, 2, 3, 4));
        exp_q.push_back(pack4(5, 6, 7, 8));
        run_burst(6'd0, 8'd2, 0, 1'b0, '0, '0);
        vec_cnt++;
        if (hs !== 2 || done_cnt !== 1 || timeout !== 0) begin
            err_cnt++;
            $display("FAIL store_ctrl: got hs=%0d done=%0d timeout=%0d required 2 1 0", hs, done_cnt, timeout);
        end
        while (exp_q.size() > 0) begin
            logic [L*DW-1:0] e;
            e = exp_q.pop_front();
            vec_cnt++;
            if (got_q.size() == 0) begin
                err_cnt++; $display("FAIL store_data: got nothing required %h", e);
            end else begin
                logic [L*DW-1:0] g;
                g = got_q.pop_front();
                if (g !== e) begin err_cnt++; $display("FAIL store_data: got %h required %h", g, e); end
                $display("store_burst: group %h", g);
            end
        end
    endtask

    task automatic test_backpressure;
        drive_cycle(1'b0, '0, '0, 1'b1, 6'd8, pack4(9, 10, 11, 12));
        exp_q.push_back(pack4(1, 2, 3, 4));
        exp_q.push_back(pack4(5, 6, 7, 8));
        exp_q.push_back(pack4(9, 10, 11, 12));
        run_burst(6'd0, 8'd3, 3, 1'b0, '0, '0);
        vec_cnt++;
        if (hs !== 3 || done_cnt !== 1 || timeout !== 0) begin
            err_cnt++;
            $display("FAIL bp_ctrl: got hs=%0d done=%0d timeout=%0d required 3 1 0", hs, done_cnt, timeout);
        end
        vec_cnt++;
        if (unstable !== 0 || st_bad !== 0) begin
            err_cnt++;
            $display("FAIL bp_stable: got unstable=%0d st_ready_high=%0d required 0 0", unstable, st_bad);
        end
        while (exp_q.size() > 0) begin
            logic [L*DW-1:0] e;
            e = exp_q.pop_front();
            vec_cnt++;
            if (got_q.size() == 0) begin
                err_cnt++; $display("FAIL bp_data: got nothing required %h", e);
            end else begin
                logic [L*DW-1:0] g;
                g = got_q.pop_front();
                if (g !== e) begin err_cnt++; $display("FAIL bp_data: got %h required %h", g, e); end
                $display("backpressure: group %h", g);
            end
        end
    endtask

    task automatic test_wrap;
        drive_cycle(1'b0, '0, '0, 1'b1, 6'd62, pack4(32'hA, 32'hB, 32'hC, 32'hD));
        exp_q.push_back(pack4(32'hA, 32'hB, 32'hC, 32'hD));
        exp_q.push_back(pack4(32'hC, 32'hD, 3, 4));
        run_burst(6'd62, 8'd1, 0, 1'b0, '0, '0);
        run_burst(6'd0, 8'd1, 0, 1'b0, '0, '0);
        // Second burst checks that lanes 2,3 of the wrapped store landed at words 0,1.
        got_q.push_front(exp_q[0]);
        exp_q.delete();
        exp_q.push_back(pack4(32'hC, 32'hD, 3, 4));
        got_q.delete(0);
        vec_cnt++;
        if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL wrap_low: got %h required %h", (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
        end
        $display("wrap: words 0..3 %h", (got_q.size() > 0) ? got_q[0] : '0);
        exp_q.delete();
        exp_q.push_back(pack4(32'hA, 32'hB, 32'hC, 32'hD));
        run_burst(6'd62, 8'd1, 0, 1'b0, '0, '0);
        while (exp_q.size() > 0) begin
            logic [L*DW-1:0] e;
            e = exp_q.pop_front();
            vec_cnt++;
            if (got_q.size() == 0) begin
                err_cnt++; $display("FAIL wrap_data: got nothing required %h", e);
            end else begin
                logic [L*DW-1:0] g;
                g = got_q.pop_front();
                if (g !== e) begin err_cnt++; $display("FAIL wrap_data: got %h required %h", g, e); end
                $display("wrap: group from 62 %h", g);
            end
        end
    endtask

    task automatic test_collision;
        drive_cycle(1'b1, 6'd5, 32'hDEAD, 1'b1, 6'd4, pack4(40, 55, 60, 70));
        exp_q.push_back(pack4(40, 55, 60, 70));
        exp_q.push_back(pack4(40, 55, 60, 70));
        exp_q.push_back(pack4(40, 32'h77, 60, 70));
        run_burst(6'd4, 8'd1, 0, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            logic [L*DW-1:0] e;
            e = exp_q.pop_front();
            vec_cnt++;
            if (got_q.size() == 0) begin
                err_cnt++; $display("FAIL collision_%0d: got nothing required %h", k, e);
            end else begin
                logic [L*DW-1:0] g;
                g = got_q.pop_front();
                if (g !== e) begin err_cnt++; $display("FAIL collision_%0d: got %h required %h", k, g, e); end
                $display("collision %0d: group %h", k, g);
            end
            if (k == 0) run_burst(6'd4, 8'd1, 0, 1'b1, 6'd5, 32'h77);
            if (k == 1) run_burst(6'd4, 8'd1, 0, 1'b0, '0, '0);
        end
    endtask

    task automatic test_reset_mid;
        int waited;
        @(negedge clk);
        ld_start = 1'b1; ld_addr = 6'd0; ld_count = 8'd5; out_ready = 1'b0;
        @(negedge clk);
        ld_start = 1'b0;
        waited = 0;
        while (!out_valid && waited < 10) begin
            @(negedge clk); waited++;
        end
        vec_cnt++;
        if (out_valid !== 1'b1) begin
            err_cnt++; $display("FAIL rst_mid_prep: got out_valid=%b required 1", out_valid);
        end
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (out_valid !== 1'b0 || ld_busy !== 1'b0 || out_data !== '0) begin
            err_cnt++;
            $display("FAIL rst_mid_abort: got v=%b busy=%b data=%h required 0 0 0", out_valid, ld_busy, out_data);
        end
        $display("reset_mid: out_valid=%b busy=%b", out_valid, ld_busy);
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (ld_done !== 1'b0) begin
            err_cnt++; $display("FAIL rst_mid_done: got ld_done=%b required 0", ld_done);
        end
        for (int k = 0; k < DEPTH / L; k++) exp_q.push_back('0);
        run_burst(6'd0, 8'(DEPTH / L), 0, 1'b0, '0, '0);
        vec_cnt++;
        if (hs !== DEPTH / L || done_cnt !== 1) begin
            err_cnt++; $display("FAIL rst_mem_ctrl: got hs=%0d done=%0d required %0d 1", hs, done_cnt, DEPTH / L);
        end
        while (exp_q.size() > 0) begin
            logic [L*DW-1:0] e;
            e = exp_q.pop_front();
            vec_cnt++;
            if (got_q.size() == 0) begin
                err_cnt++; $display("FAIL rst_mem: got nothing required %h", e);
            end else begin
                logic [L*DW-1:0] g;
                g = got_q.pop_front();
                if (g !== e) begin err_cnt++; $display("FAIL rst_mem: got %h required %h", g, e); end
            end
        end
        run_burst(6'd0, 8'd0, 0, 1'b0, '0, '0);
        vec_cnt++;
        if (hs !== 0 || done_cnt !== 1 || timeout !== 0 || first_valid !== -1) begin
            err_cnt++;
            $display("FAIL zero_count: got hs=%0d done=%0d timeout=%0d first_valid=%0d required 0 1 0 -1", hs, done_cnt, timeout, first_valid);
        end
        $display("zero_count: handshakes=%0d done pulses=%0d", hs, done_cnt);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        test_reset;
        reset = 1'b0;
        test_preload;
        test_store_burst;
        test_backpressure;
        test_wrap;
        test_collision;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/unified_buffer_param.md
Name: unified_buffer_param

Overview:
Parametrised on-chip activation/result memory between the accumulators and the input-setup stage. It generalises the fixed 64x32, 4-word unified buffer in four ways:
- configurable width, depth and lane count;
- valid/ready store handshake;
- host preload port, replacing hard-coded dummy activations;
- multi-group burst load FSM with output backpressure.
Stores and burst reads run against one register-array memory.

Parameters:
DATA_W, 32, bits per word
DEPTH, 64, words in memory; power of two, at least LANES
LANES, 4, words moved per store beat and per load beat
ADDR_W, 6, address width; must equal log2(DEPTH)
CNT_W, 8, width of burst group count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
host_wr_en  in  1  single-word preload write enable
host_wr_addr  in  ADDR_W  preload address
host_wr_data  in  DATA_W  preload data
st_valid  in  1  accumulator store beat valid
st_ready  out  1  store beat accepted when high with st_valid
st_addr  in  ADDR_W  base word address of store beat
st_data  in  LANES*DATA_W  lane i in bits [i*DATA_W +: DATA_W], written to st_addr+i
ld_start  in  1  start burst load; sampled only in IDLE
ld_addr  in  ADDR_W  burst base word address
ld_count  in  CNT_W  number of LANES-word groups to load
ld_busy  out  1  FSM not in IDLE
ld_done  out  1  one-cycle pulse when last group is consumed
out_valid  out  1  out_data holds a valid group
out_ready  in  1  input-setup consumer ready
out_data  out  LANES*DATA_W  lane i = mem[group base + i]

Behaviour:
- Reset (async, immediate):
  - all memory words = 0; out_data = 0; out_valid = 0; ld_done = 0; FSM = IDLE; internal pointer and count = 0.
  - st_ready = 1, since it is combinational from FSM state.
  - Reset mid-burst aborts the burst: out_valid drops with reset, no ld_done.
- Addressing: every lane address is (base + i) mod DEPTH. Wrap-around is legal and silent; there is no error flag.
- Store:
  - st_ready = (state == IDLE). Stores stall while a burst load is active.
  - On an edge with st_valid && st_ready, all LANES words are written in that cycle.
- Host write: writes one word per edge when host_wr_en, in any state.
- Same-cycle write collision (same word): store lane wins over host write.
- Reads are synchronous and read-before-write: a group read on the same edge as a write to that word returns the old value.
- FSM states: IDLE, LOAD, DRAIN.
- IDLE:
  - ld_start && ld_count != 0 → LOAD; ptr = ld_addr; rem = ld_count.
  - ld_start && ld_count == 0 → stay IDLE; ld_done pulses the next cycle; no data is produced.
  - ld_start in any other state is ignored.
- LOAD, each edge, with issue = !out_valid || out_ready:
  - if issue: out_data <= group at ptr; out_valid <= 1; ptr += LANES (mod DEPTH); rem -= 1.
  - if rem becomes 0 on this edge → DRAIN.
  - if !issue: out_data and out_valid hold (backpressure; data stable while out_valid && !out_ready).
- DRAIN:
  - on out_valid && out_ready: out_valid <= 0; ld_done <= 1 for one cycle; → IDLE.
  - otherwise hold.
- Latency: ld_start accepted at edge T → first out_valid high after edge T+1. With out_ready held high, groups stream one per cycle. ld_done is high after the edge following the last handshake.
- ld_busy = (state != IDLE).
- Unbounded: ld_count up to 2^CNT_W-1; ptr wraps repeatedly if the burst exceeds DEPTH.

Test Plan:
- Preload: host writes mem[30..33] = 11,12,21,22, then ld_start with ld_addr=30, ld_count=1, out_ready=1 → one group out_data = {22,21,12,11} (lane0 = 11); ld_done pulses; ld_busy low afterwards.
- Store then burst: store beats at addr 0 = {1,2,3,4} and addr 4 = {5,6,7,8}; ld_addr=0, ld_count=2 → two consecutive beats {1..4}, {5..8}.
- Backpressure: ld_count=3, out_ready low for 3 cycles after the first out_valid → out_data stable and no beat lost or duplicated; total handshakes = 3; st_ready = 0 throughout the burst.
- Wrap-around: store at addr 62 (DEPTH=64) of {A,B,C,D} → mem[62]=A, mem[63]=B, mem[0]=C, mem[1]=D; burst from 62 returns {A,B,C,D}.
- Collisions:
  - host_wr and store to word 5 in the same cycle → store value kept.
  - burst read issuing group 4..7 on the same edge as a host write to word 5 → old word 5 returned.
- Reset during LOAD with out_valid=1 → out_valid = 0 immediately; memory is all 0 afterwards; ld_count=0 start → ld_done pulse and no out_valid.
